// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with per-entry saturating direction counters
// Optional statistics counters are built when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int XLEN     = 32,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_br,
  input  logic            ex_is_jmp,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_mispredict,
  output logic [XLEN-1:0] ex_redirect_pc,
  input  logic            flush_all
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
  output logic [31:0]     stat_btb_allocs
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic                jmp_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                ex_is_ctl, ex_hit;
  logic                wr_en, alloc;
  logic                valid_d, jmp_d;
  logic [TAG_W-1:0]    tag_d;
  logic [XLEN-1:0]     target_d;
  logic [CTR_BITS-1:0] ctr_d;
  logic                unused_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && (jmp_q[if_idx] || ctr_q[if_idx][CTR_BITS-1]);
  assign pred_target = pred_taken ? target_q[if_idx]
                                  : ({if_pc[XLEN-1:2], 2'b00} + XLEN'(4));

  assign ex_mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                       (ex_taken && (ex_target != ex_pred_target)));
  assign ex_redirect_pc = !ex_valid ? '0 :
                          ex_taken  ? ex_target : ({ex_pc[XLEN-1:2], 2'b00} + XLEN'(4));

  assign ex_is_ctl = ex_is_br || ex_is_jmp;
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A set jmp flag dominates, which also covers the illegal br+jmp combination.
  always_comb begin
    wr_en    = 1'b0;
    alloc    = 1'b0;
    valid_d  = valid_q[ex_idx];
    tag_d    = tag_q[ex_idx];
    target_d = target_q[ex_idx];
    jmp_d    = jmp_q[ex_idx];
    ctr_d    = ctr_q[ex_idx];
    if (ex_valid && !flush_all) begin
      if (ex_is_ctl && ex_hit) begin
        wr_en = 1'b1;
        if (ex_is_jmp)
          ctr_d = CTR_MAX;
        else if (ex_taken)
          ctr_d = (ctr_q[ex_idx] == CTR_MAX) ? CTR_MAX : ctr_q[ex_idx] + CTR_BITS'(1);
        else
          ctr_d = (ctr_q[ex_idx] == '0) ? '0 : ctr_q[ex_idx] - CTR_BITS'(1);
        if (ex_taken)
          target_d = ex_target;
      end else if (ex_is_ctl && ex_taken) begin
        wr_en    = 1'b1;
        alloc    = 1'b1;
        valid_d  = 1'b1;
        tag_d    = ex_tag;
        target_d = ex_target;
        jmp_d    = ex_is_jmp;
        ctr_d    = ex_is_jmp ? CTR_MAX : CTR_WT;
      end else if (!ex_is_ctl && ex_hit) begin
        wr_en   = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jmp_q[i]    <= 1'b0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= valid_d;
      tag_q[ex_idx]    <= tag_d;
      target_q[ex_idx] <= target_d;
      jmp_q[ex_idx]    <= jmp_d;
      ctr_q[ex_idx]    <= ctr_d;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q, stat_btb_allocs_q;

  // Statistics survive flush_all; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      stat_btb_allocs_q  <= '0;
    end else begin
      if (ex_valid && ex_is_ctl) stat_branches_q    <= stat_branches_q + 32'd1;
      if (ex_mispredict)         stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      if (alloc)                 stat_btb_allocs_q  <= stat_btb_allocs_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
  assign stat_btb_allocs  = stat_btb_allocs_q;
`endif

endmodule
